// File: rtl/frame_update_ctrl.sv
// Once-per-frame scheduler: runs SUBSTEPS rope physics steps after each vsync,
// then commits a tear-free copy of the ball position to the renderer.
module frame_update_ctrl #(
    parameter int SUBSTEPS = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_start,
    input  logic       enable,
    input  logic       clear_err,
    input  logic       step_ack,
    input  logic [9:0] ball_x_in,
    input  logic [9:0] ball_y_in,
    output logic       step_req,
    output logic [9:0] ball_x_out,
    output logic [9:0] ball_y_out,
    output logic       commit,
    output logic       busy,
    output logic       overrun,
    output logic       timeout,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {IDLE, REQ, GAP, COMMIT} state_t;

    localparam logic [3:0] STEP_LAST = 4'(SUBSTEPS);
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT);

    state_t     state, state_nxt;
    logic [3:0] step_cnt;
    logic [9:0] wait_cnt;
    logic       start;
    logic       step_done;
    logic       wait_expired;

    assign start        = (state == IDLE) && vsync_start && enable;
    assign step_done    = ((step_cnt + 4'd1) == STEP_LAST);
    assign wait_expired = (state == REQ) && !step_ack && ((wait_cnt + 10'd1) == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ: begin
                if (step_ack) begin
                    state_nxt = step_done ? COMMIT : GAP;
                end else if (wait_expired) begin
                    state_nxt = IDLE;
                end
            end
            GAP:     state_nxt = REQ;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        step_req = (state == REQ);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= 4'd0;
            wait_cnt <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        step_cnt <= 4'd0;
                        wait_cnt <= 10'd0;
                    end
                end
                REQ: begin
                    if (step_ack) begin
                        step_cnt <= step_cnt + 4'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                GAP:     wait_cnt <= 10'd0;
                default: ;
            endcase
        end
    end

    // Commit stage: the renderer-facing copy only moves here, so it never tears mid-frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit      <= 1'b0;
            ball_x_out  <= 10'd0;
            ball_y_out  <= 10'd0;
            frame_count <= 16'd0;
        end else begin
            commit <= (state == COMMIT);
            if (state == COMMIT) begin
                ball_x_out  <= ball_x_in;
                ball_y_out  <= ball_y_in;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Sticky error flags; a set event in the same cycle as clear_err wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            overrun <= (vsync_start && (state != IDLE)) || (overrun && !clear_err);
            timeout <= wait_expired || (timeout && !clear_err);
        end
    end

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Scoreboard bench for frame_update_ctrl: stimulus pushes expected commits,
// a monitor pops and compares whenever commit is presented.
`timescale 1ns/1ps
module tb_frame_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync_start;
    logic        enable;
    logic        clear_err;
    logic        step_ack;
    logic [9:0]  ball_x_in;
    logic [9:0]  ball_y_in;
    logic        step_req;
    logic [9:0]  ball_x_out;
    logic [9:0]  ball_y_out;
    logic        commit;
    logic        busy;
    logic        overrun;
    logic        timeout;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    frame_update_ctrl #(.SUBSTEPS(4), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .vsync_start(vsync_start), .enable(enable),
        .clear_err(clear_err), .step_ack(step_ack),
        .ball_x_in(ball_x_in), .ball_y_in(ball_y_in),
        .step_req(step_req), .ball_x_out(ball_x_out), .ball_y_out(ball_y_out),
        .commit(commit), .busy(busy), .overrun(overrun), .timeout(timeout),
        .frame_count(frame_count)
    );

    // Rope engine model: 0 = never ack, 1 = ack tied to req, 2 = ack after 5 req cycles, 3 = ack stuck high
    int ack_mode = 0;
    int req_cnt  = 0;
    always @(posedge clk) req_cnt <= step_req ? req_cnt + 1 : 0;
    assign step_ack = (ack_mode == 1) ? step_req :
                      (ack_mode == 2) ? (step_req && (req_cnt >= 5)) :
                      (ack_mode == 3);

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] fc;
    } exp_t;
    exp_t sb[$];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_fc      = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (commit === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_commit: got commit with x=%0d y=%0d fc=%0d, expected none",
                         ball_x_out, ball_y_out, frame_count);
            end else begin
                e = sb.pop_front();
                check("commit_x", ball_x_out, e.x);
                check("commit_y", ball_y_out, e.y);
                check("commit_fc", frame_count, e.fc);
            end
        end
    end

    task automatic pulse_vsync();
        @(negedge clk) vsync_start = 1'b1;
        @(negedge clk) vsync_start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear_err = 1'b1;
        @(negedge clk) clear_err = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_bound", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [9:0] x, input logic [9:0] y);
        exp_fc = exp_fc + 16'd1;
        sb.push_back('{x: x, y: y, fc: exp_fc});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] req_pat;
        logic [8:0] busy_pat;
        logic [8:0] commit_pat;
        int         cnt;

        reset = 1'b0; vsync_start = 1'b0; enable = 1'b0; clear_err = 1'b0;
        ball_x_in = 10'd0; ball_y_in = 10'd0;
        repeat (2) @(negedge clk);
        check("rst_step_req", step_req, 0);
        check("rst_busy", busy, 0);
        check("rst_commit", commit, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_ball_x", ball_x_out, 0);
        check("rst_ball_y", ball_y_out, 0);
        reset = 1'b1;
        @(negedge clk);

        // Zero-latency ack frame: req pattern 1010101 then COMMIT, commit pulse with busy low
        req_pat    = 9'b001010101;
        busy_pat   = 9'b011111111;
        commit_pat = 9'b100000000;
        enable = 1'b1; ack_mode = 1; ball_x_in = 10'd100; ball_y_in = 10'd50;
        expect_frame(10'd100, 10'd50);
        pulse_vsync();
        for (int n = 0; n < 9; n++) begin
            check($sformatf("zl_req_%0d", n), step_req, req_pat[n]);
            check($sformatf("zl_busy_%0d", n), busy, busy_pat[n]);
            check($sformatf("zl_commit_%0d", n), commit, commit_pat[n]);
            @(negedge clk);
        end
        @(negedge clk);
        check("zl_hold_x", ball_x_out, 100);
        check("zl_fc", frame_count, 1);

        // Reset mid-REQ aborts at once
        ack_mode = 0;
        pulse_vsync();
        repeat (3) @(negedge clk);
        check("mid_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", step_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fc", frame_count, 0);
        check("mid_rst_x", ball_x_out, 0);
        check("mid_rst_y", ball_y_out, 0);
        @(negedge clk) reset = 1'b1;
        exp_fc = 16'd0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_start", busy, 0);

        // Ack delayed 5 cycles, inputs change every cycle: COMMIT cycle is n=27
        ack_mode = 2;
        expect_frame(10'd227, 10'd581);
        pulse_vsync();
        for (int n = 0; n <= 40; n++) begin
            ball_x_in = 10'(200 + n);
            ball_y_in = 10'(500 + 3 * n);
            @(negedge clk);
        end
        check("dly_hold_x", ball_x_out, 227);
        check("dly_hold_y", ball_y_out, 581);
        check("dly_busy", busy, 0);

        // Overrun: re-pulse while busy, then clear collides with a set
        ack_mode = 1; ball_x_in = 10'd300; ball_y_in = 10'd400;
        check("ovr_initial", overrun, 0);
        expect_frame(10'd300, 10'd400);
        pulse_vsync();
        repeat (2) @(negedge clk);
        vsync_start = 1'b1;
        @(negedge clk);
        check("ovr_set", overrun, 1);
        clear_err = 1'b1;
        @(negedge clk);
        vsync_start = 1'b0; clear_err = 1'b0;
        check("ovr_set_wins", overrun, 1);
        wait_idle(50);
        check("ovr_sticky", overrun, 1);
        pulse_clear();
        check("ovr_cleared", overrun, 0);

        // Timeout: no ack for 1023 REQ cycles
        ack_mode = 0;
        pulse_vsync();
        cnt = 0;
        while (step_req && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("to_req_cycles", cnt, 1023);
        check("to_flag", timeout, 1);
        check("to_busy", busy, 0);
        check("to_fc_unchanged", frame_count, exp_fc);
        ack_mode = 1; ball_x_in = 10'd11; ball_y_in = 10'd22;
        expect_frame(10'd11, 10'd22);
        pulse_vsync();
        wait_idle(50);
        check("to_still_set", timeout, 1);
        pulse_clear();
        check("to_cleared", timeout, 0);

        // Ack stuck high: ignored outside REQ, frame still takes four steps
        ack_mode = 3; ball_x_in = 10'd7; ball_y_in = 10'd9;
        repeat (3) @(negedge clk);
        check("ack_idle_ignored", busy, 0);
        expect_frame(10'd7, 10'd9);
        pulse_vsync();
        wait_idle(50);

        // Disabled start
        enable = 1'b0; ack_mode = 1;
        pulse_vsync();
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (step_req) cnt++;
            @(negedge clk);
        end
        check("dis_no_req", cnt, 0);
        check("dis_busy", busy, 0);

        // Frame counter wrap
        enable = 1'b1;
        @(negedge clk) force dut.frame_count = 16'hFFFF;
        @(negedge clk) release dut.frame_count;
        @(negedge clk);
        check("wrap_preload", frame_count, 16'hFFFF);
        exp_fc = 16'hFFFF;
        ball_x_in = 10'd1023; ball_y_in = 10'd0;
        expect_frame(10'd1023, 10'd0);
        pulse_vsync();
        wait_idle(50);
        check("wrap_fc", frame_count, 0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
